// File: rtl/conv_pkg.sv
// conv_pkg: shared types and width helpers for the conv_pool_stream slice.
//   state_t      frame-sequencing states
//   clog2_min1() ceil(log2(n)), never below 1, for counter/address widths
//   acc_width()  accumulator width that cannot overflow for a kk-tap MAC
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_POOL,
        S_DONE
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // pixel is unsigned, so it needs one extra bit to become a signed
    // multiplicand; clog2(kk) covers the growth of the kk-term sum
    function automatic int acc_width(input int dw, input int kw, input int kk);
        return dw + kw + 1 + $clog2(kk);
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// conv_window_mac: combinational K*K multiply-accumulate of one window.
//   win   unsigned window pixels, tap t = row*K + col
//   coef  signed coefficients, same tap order
//   sum   signed sum of win[t]*coef[t], ACC_W wide
module conv_window_mac #(
    parameter int KK     = 9,
    parameter int DATA_W = 8,
    parameter int KW_W   = 8,
    parameter int ACC_W  = 21
) (
    input  logic [KK-1:0][DATA_W-1:0] win,
    input  logic [KK-1:0][KW_W-1:0]   coef,
    output logic signed [ACC_W-1:0]   sum
);

    always_comb begin
        sum = '0;
        for (int t = 0; t < KK; t++) begin
            // zero-extend the pixel, sign-extend the coefficient, then
            // multiply at full accumulator width
            sum = sum + ACC_W'($signed({1'b0, win[t]})) * ACC_W'($signed(coef[t]));
        end
    end

endmodule

// File: rtl/conv_pool_stream.sv
// conv_pool_stream: frame-based K x K valid correlation followed by
// POOL x POOL max pooling, with a ready/valid pixel input and result output.
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin a frame (IDLE only)
//   k_we/k_addr/k_data coefficient write port (IDLE only), row-major index
//   pix_valid/ready/data  pixel stream, row-major, accepted in LOAD
//   out_valid/ready/data/last  pooled results, row-major, emitted in POOL
//   busy               state != IDLE
//   done               one-cycle pulse in DONE
// Build option: define CONV_RELU_EN to clamp negative convolution results
// to zero before they are stored and pooled.
module conv_pool_stream import conv_pkg::*; #(
    parameter  int IMG_W  = 28,
    parameter  int IMG_H  = 28,
    parameter  int K      = 3,
    parameter  int DATA_W = 8,
    parameter  int KW_W   = 8,
    parameter  int POOL   = 2,
    localparam int ACC_W  = acc_width(DATA_W, KW_W, K * K),
    localparam int KA_W   = clog2_min1(K * K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              k_we,
    input  logic [KA_W-1:0]   k_addr,
    input  logic [KW_W-1:0]   k_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COW   = IMG_W - K + 1;
    localparam int COH   = IMG_H - K + 1;
    localparam int NCONV = COW * COH;
    localparam int PW    = COW / POOL;
    localparam int PH    = COH / POOL;
    localparam int NBEAT = PW * PH;
    localparam int PA_W  = clog2_min1(NPIX);
    localparam int CA_W  = clog2_min1(NCONV);
    localparam int CX_W  = clog2_min1(COW);
    localparam int CY_W  = clog2_min1(COH);
    localparam int QX_W  = clog2_min1(PW);
    localparam int QY_W  = clog2_min1(PH);

    state_t state, state_nxt;

    logic [PA_W-1:0] pix_cnt;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic [CA_W-1:0] conv_idx;
    logic [QX_W-1:0] qx;
    logic [QY_W-1:0] qy;

    logic        [DATA_W-1:0] img      [NPIX];
    logic signed [KW_W-1:0]   coef     [K*K];
    logic signed [ACC_W-1:0]  conv_mem [NCONV];

    logic [K*K-1:0][DATA_W-1:0] win;
    logic [K*K-1:0][KW_W-1:0]   coef_flat;
    logic signed [ACC_W-1:0]    mac_sum;
    logic signed [ACC_W-1:0]    conv_val;
    logic signed [ACC_W-1:0]    pool_max;
    logic signed [ACC_W-1:0]    cand;

    logic last_pix, last_conv, last_beat;

    assign last_pix  = (pix_cnt == PA_W'(NPIX - 1));
    assign last_conv = (conv_idx == CA_W'(NCONV - 1));
    assign last_beat = (qx == QX_W'(PW - 1)) && (qy == QY_W'(PH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: if (pix_valid && last_pix) state_nxt = S_CONV;
            // a geometry with no full pool window has nothing to emit
            S_CONV: if (last_conv) state_nxt = (NBEAT > 0) ? S_POOL : S_DONE;
            S_POOL: if (out_ready && last_beat) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- counters and coefficients ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            cx       <= '0;
            cy       <= '0;
            conv_idx <= '0;
            qx       <= '0;
            qy       <= '0;
            for (int t = 0; t < K * K; t++) coef[t] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // every frame starts from zero, so an aborted frame
                    // leaves nothing behind
                    pix_cnt  <= '0;
                    cx       <= '0;
                    cy       <= '0;
                    conv_idx <= '0;
                    qx       <= '0;
                    qy       <= '0;
                    if (k_we && (int'(k_addr) < K * K)) coef[k_addr] <= k_data;
                end
                S_LOAD: if (pix_valid) pix_cnt <= pix_cnt + 1'b1;
                S_CONV: begin
                    conv_idx <= conv_idx + 1'b1;
                    if (cx == CX_W'(COW - 1)) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                S_POOL: if (out_ready) begin
                    if (qx == QX_W'(PW - 1)) begin
                        qx <= '0;
                        qy <= qy + 1'b1;
                    end else begin
                        qx <= qx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- frame and feature-map storage ----------------
    always_ff @(posedge clk) begin
        if (state == S_LOAD && pix_valid) img[pix_cnt] <= pix_data;
        if (state == S_CONV)              conv_mem[conv_idx] <= conv_val;
    end

    // ---------------- convolution ----------------
    always_comb begin
        win       = '0;
        coef_flat = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win[i*K+j]       = img[PA_W'((int'(cy) + i) * IMG_W + int'(cx) + j)];
                coef_flat[i*K+j] = coef[i*K+j];
            end
        end
    end

    conv_window_mac #(
        .KK    (K * K),
        .DATA_W(DATA_W),
        .KW_W  (KW_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .win (win),
        .coef(coef_flat),
        .sum (mac_sum)
    );

`ifdef CONV_RELU_EN
    assign conv_val = mac_sum[ACC_W-1] ? '0 : mac_sum;
`else
    assign conv_val = mac_sum;
`endif

    // ---------------- max pooling ----------------
    // window read straight from the feature map; the counters only move on
    // a handshake, so the presented beat stays stable while stalled
    always_comb begin
        pool_max = conv_mem[CA_W'(int'(qy) * POOL * COW + int'(qx) * POOL)];
        cand     = '0;
        for (int a = 0; a < POOL; a++) begin
            for (int b = 0; b < POOL; b++) begin
                cand = conv_mem[CA_W'((int'(qy) * POOL + a) * COW + int'(qx) * POOL + b)];
                if (cand > pool_max) pool_max = cand;
            end
        end
    end

    // ---------------- outputs ----------------
    assign pix_ready = (state == S_LOAD);
    assign out_valid = (state == S_POOL);
    assign out_data  = out_valid ? pool_max : '0;
    assign out_last  = out_valid && last_beat;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_conv_pool_stream.sv
module tb_conv_pool_stream;

    localparam int ND = 3;  // 0: 4x4, 1: 5x5, 2: 28x28 defaults

    logic clk = 1'b0;
    logic rst_n;
    logic [ND-1:0]       start, k_we, pix_valid, out_ready;
    logic [ND-1:0][3:0]  k_addr;
    logic [ND-1:0][7:0]  k_data, pix_data;
    wire  [ND-1:0]       pix_ready, out_valid, out_last, busy, done;
    wire  [ND-1:0][20:0] out_data;

    int checks = 0;
    int errors = 0;

    int img_m  [784];
    int kc_m   [9];
    int conv_m [784];
    int exp_q  [$];

    always #5 clk = ~clk;

    conv_pool_stream #(.IMG_W(4), .IMG_H(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .k_we(k_we[0]),
        .k_addr(k_addr[0]), .k_data(k_data[0]), .pix_valid(pix_valid[0]),
        .pix_ready(pix_ready[0]), .pix_data(pix_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .busy(busy[0]), .done(done[0])
    );

    conv_pool_stream #(.IMG_W(5), .IMG_H(5)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .k_we(k_we[1]),
        .k_addr(k_addr[1]), .k_data(k_data[1]), .pix_valid(pix_valid[1]),
        .pix_ready(pix_ready[1]), .pix_data(pix_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .busy(busy[1]), .done(done[1])
    );

    conv_pool_stream u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .k_we(k_we[2]),
        .k_addr(k_addr[2]), .k_data(k_data[2]), .pix_valid(pix_valid[2]),
        .pix_ready(pix_ready[2]), .pix_data(pix_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
        .busy(busy[2]), .done(done[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: direct 3x3 correlation over the image, then 2x2/stride-2 max,
    // dropping any trailing row/column of the feature map.
    function automatic void model(input int w, input int h);
        int cow, coh, s, m;
        cow = w - 2;
        coh = h - 2;
        exp_q.delete();
        for (int y = 0; y < coh; y++)
            for (int x = 0; x < cow; x++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += img_m[(y + i) * w + x + j] * kc_m[i * 3 + j];
`ifdef CONV_RELU_EN
                if (s < 0) s = 0;
`endif
                conv_m[y * cow + x] = s;
            end
        for (int py = 0; py < coh / 2; py++)
            for (int px = 0; px < cow / 2; px++) begin
                m = conv_m[2 * py * cow + 2 * px];
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        if (conv_m[(2 * py + a) * cow + 2 * px + b] > m)
                            m = conv_m[(2 * py + a) * cow + 2 * px + b];
                exp_q.push_back(m);
            end
    endfunction

    task automatic load_coeffs(input int d);
        for (int i = 0; i < 9; i++) begin
            k_we[d]   = 1'b1;
            k_addr[d] = 4'(i);
            k_data[d] = 8'(kc_m[i]);
            tick();
        end
        k_we[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, input int w, input int h, input bit load_k,
                             input int stall, input bit rnd_rdy);
        int n, g, beats, st;
        bit v, r, held, hl;
        logic signed [31:0] hd;
        model(w, h);
        if (load_k) load_coeffs(d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        chk("busy_load", busy[d], 1);
        chk("pix_ready_load", pix_ready[d], 1);
        // pixels with random gaps; stray coefficient writes and starts must be ignored
        n = 0;
        g = 0;
        while (n < w * h && g < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            pix_valid[d] = v;
            pix_data[d]  = 8'(img_m[n]);
            k_we[d]      = 1'($urandom_range(0, 1));
            k_addr[d]    = 4'($urandom_range(0, 8));
            k_data[d]    = 8'($urandom);
            start[d]     = 1'($urandom_range(0, 1));
            if (v && pix_ready[d]) n++;
            tick();
            g++;
        end
        chk("pix_count", n, w * h);
        k_we[d]      = 1'b0;
        start[d]     = 1'b0;
        pix_valid[d] = 1'b1;
        pix_data[d]  = 8'hff;
        chk("pix_ready_after_load", pix_ready[d], 0);
        tick();
        tick();
        pix_valid[d] = 1'b0;
        // collect pooled beats
        beats = 0;
        g = 0;
        st = 0;
        held = 0;
        hd = 0;
        hl = 0;
        while (beats < exp_q.size() && g < 40000) begin
            if (held) begin
                chk("hold_valid", out_valid[d], 1);
                chk("hold_data", $signed(out_data[d]), hd);
                chk("hold_last", out_last[d], hl);
            end
            if (out_valid[d] && st < stall) begin
                r = 1'b0;
                st++;
            end else begin
                r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            out_ready[d] = r;
            if (out_valid[d] && r) begin
                chk($sformatf("beat%0d_data", beats), $signed(out_data[d]), exp_q[beats]);
                chk($sformatf("beat%0d_last", beats), out_last[d],
                    (beats == exp_q.size() - 1) ? 1 : 0);
                beats++;
                held = 0;
            end else if (out_valid[d]) begin
                held = 1;
                hd = $signed(out_data[d]);
                hl = out_last[d];
            end else begin
                held = 0;
            end
            tick();
            g++;
        end
        chk("beat_count", beats, exp_q.size());
        out_ready[d] = 1'b0;
        chk("done_pulse", done[d], 1);
        chk("busy_in_done", busy[d], 1);
        chk("valid_in_done", out_valid[d], 0);
        tick();
        chk("done_clear", done[d], 0);
        chk("busy_idle", busy[d], 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = '0;
        k_we      = '0;
        k_addr    = '0;
        k_data    = '0;
        pix_valid = '0;
        pix_data  = '0;
        out_ready = '0;
        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            chk("rst_pix_ready", pix_ready[d], 0);
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_out_data", $signed(out_data[d]), 0);
            chk("rst_out_last", out_last[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
        end
        rst_n = 1'b1;
        tick();

        // 4x4, all ones: single beat of 9
        for (int i = 0; i < 16; i++) img_m[i] = 1;
        for (int i = 0; i < 9; i++) kc_m[i] = 1;
        run_frame(0, 4, 4, 1, 0, 0);

        // same frame, sink stalls 5 cycles; coefficients kept from last frame
        run_frame(0, 4, 4, 0, 5, 0);

        // 4x4, pixels 10, coeffs -1: -90 raw, 0 when clamped
        for (int i = 0; i < 16; i++) img_m[i] = 10;
        for (int i = 0; i < 9; i++) kc_m[i] = -1;
        run_frame(0, 4, 4, 1, 0, 1);

        // random 4x4 frames with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) img_m[i] = $urandom_range(0, 255);
            for (int i = 0; i < 9; i++) kc_m[i] = $urandom_range(0, 255) - 128;
            run_frame(0, 4, 4, 1, 2, 1);
        end

        // 5x5: 3x3 feature map, one beat; second frame reuses coefficients
        for (int i = 0; i < 25; i++) img_m[i] = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++) kc_m[i] = $urandom_range(0, 255) - 128;
        run_frame(1, 5, 5, 1, 0, 1);
        for (int i = 0; i < 25; i++) img_m[i] = $urandom_range(0, 255);
        run_frame(1, 5, 5, 0, 3, 1);

        // 28x28: pixel = column index, centre tap only -> 169 beats
        for (int i = 0; i < 784; i++) img_m[i] = i % 28;
        for (int i = 0; i < 9; i++) kc_m[i] = 0;
        kc_m[4] = 1;
        run_frame(2, 28, 28, 1, 0, 0);

        // reset after 10 pixels of a 4x4 frame
        for (int i = 0; i < 9; i++) kc_m[i] = $urandom_range(0, 255) - 128;
        load_coeffs(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix_valid[0] = 1'b1;
            pix_data[0]  = 8'($urandom);
            tick();
        end
        chk("pix_ready_before_rst", pix_ready[0], 1);
        rst_n = 1'b0;
        pix_valid[0] = 1'b0;
        tick();
        chk("rst_mid_pix_ready", pix_ready[0], 0);
        chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_out_valid", out_valid[0], 0);
        rst_n = 1'b1;
        tick();

        // reset cleared the coefficients: full 16-pixel frame, all-zero result
        for (int i = 0; i < 9; i++) kc_m[i] = 0;
        for (int i = 0; i < 16; i++) img_m[i] = $urandom_range(0, 255);
        run_frame(0, 4, 4, 0, 0, 1);

        // and a fresh random frame afterwards
        for (int i = 0; i < 9; i++) kc_m[i] = $urandom_range(0, 255) - 128;
        run_frame(0, 4, 4, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
